// File: rtl/la_dpram_pipe.sv
// Single-clock 1W/1R RAM with pipelined read latency, configurable collision
// policy and a post-reset clear sequencer that zeroes the array.
module la_dpram_pipe #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 10,
    parameter int unsigned DEPTH     = 2**AW,
    parameter int unsigned RDLAT     = 1,
    parameter string       COLLISION = "WRITE_FIRST",
    parameter int unsigned CLEAR     = 1,
    parameter string       TYPE      = "DEFAULT",
    parameter int unsigned CTRLW     = 128,
    parameter int unsigned TESTW     = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_ce,
    input  logic             wr_we,
    input  logic [DW-1:0]    wr_wmask,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_din,
    input  logic             rd_ce,
    input  logic [AW-1:0]    rd_addr,
    output logic [DW-1:0]    rd_dout,
    output logic             rd_valid,
    output logic             init_busy,
    input  logic             vss,
    input  logic             vdd,
    input  logic             vddio,
    input  logic [CTRLW-1:0] ctrl,
    input  logic [TESTW-1:0] test
);

    localparam bit          WR_FIRST = (COLLISION != "READ_FIRST");
    localparam logic [AW:0] CLR_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam bit          unused_type_sel = (TYPE == "DEFAULT");

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW:0]     clr_addr;
    logic [AW:0]     clr_addr_nxt;

    logic [DW-1:0]   mem [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;

    logic            wr_hit;
    logic            rd_hit;
    logic            wr_eff;
    logic            rd_go;
    logic [DW-1:0]   wr_merged;
    logic [DW-1:0]   rd_data;

    logic [DW-1:0]   pipe_d [RDLAT];
    logic [RDLAT-1:0] pipe_v;

    logic            unused_ok;
    assign unused_ok = ^{vss, vdd, vddio, ctrl, test};

    // State register; reset restarts the clear sweep from address 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (CLEAR != 0) ? ST_CLEAR : ST_IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // Next-state: sweep one entry per cycle, leave on the last entry
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        if (state == ST_CLEAR) begin
            clr_addr_nxt = clr_addr + (AW+1)'(1);
            if (clr_addr == CLR_LAST) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // State outputs and port qualification
    always_comb begin
        init_busy = (state == ST_CLEAR);
        wr_hit    = wr_ce & wr_we & ({1'b0, wr_addr} < DEPTH_W);
        rd_hit    = ({1'b0, rd_addr} < DEPTH_W);
        wr_eff    = ~rst & ~init_busy & wr_hit;
        rd_go     = rd_ce & ~init_busy;
    end

    assign wr_merged = (wr_din & wr_wmask) | (mem[wr_addr] & ~wr_wmask);

    // Single array write port shared by the clear sweep and the user write
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_merged;
        if (!rst && init_busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr[AW-1:0];
            mem_wdata = '0;
        end else if (wr_eff) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Array read with write-first bypass on a same-address collision
    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            if (WR_FIRST && wr_eff && (wr_addr == rd_addr)) begin
                rd_data = wr_merged;
            end else begin
                rd_data = mem[rd_addr];
            end
        end
    end

    // Read pipeline; data stages only load behind a valid so the output holds
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < RDLAT; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_go;
            if (rd_go) begin
                pipe_d[0] <= rd_data;
            end
            for (int i = 1; i < RDLAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end
    end

    assign rd_dout  = pipe_d[RDLAT-1];
    assign rd_valid = pipe_v[RDLAT-1];

endmodule

// File: tb/tb_la_dpram_pipe.sv
// Directed bench for la_dpram_pipe: five configurations share one stimulus bus.
module tb_la_dpram_pipe;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_ce, wr_we, rd_ce;
    logic [DW-1:0] wr_wmask, wr_din;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [127:0]  ctrl_z = '0;
    logic [127:0]  test_z = '0;

    logic [DW-1:0] d1, d3, dr, d2, d12;
    logic          v1, v3, vr, v2, v12;
    logic          b1, b3, br, b2, b12;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    la_dpram_pipe #(.DW(DW), .AW(AW), .RDLAT(1), .COLLISION("WRITE_FIRST"), .CLEAR(1)) u1 (
        .clk(clk), .rst(rst), .wr_ce(wr_ce), .wr_we(wr_we), .wr_wmask(wr_wmask),
        .wr_addr(wr_addr), .wr_din(wr_din), .rd_ce(rd_ce), .rd_addr(rd_addr),
        .rd_dout(d1), .rd_valid(v1), .init_busy(b1),
        .vss(1'b0), .vdd(1'b1), .vddio(1'b1), .ctrl(ctrl_z), .test(test_z));

    la_dpram_pipe #(.DW(DW), .AW(AW), .RDLAT(3), .COLLISION("WRITE_FIRST"), .CLEAR(1)) u3 (
        .clk(clk), .rst(rst), .wr_ce(wr_ce), .wr_we(wr_we), .wr_wmask(wr_wmask),
        .wr_addr(wr_addr), .wr_din(wr_din), .rd_ce(rd_ce), .rd_addr(rd_addr),
        .rd_dout(d3), .rd_valid(v3), .init_busy(b3),
        .vss(1'b0), .vdd(1'b1), .vddio(1'b1), .ctrl(ctrl_z), .test(test_z));

    la_dpram_pipe #(.DW(DW), .AW(AW), .RDLAT(1), .COLLISION("READ_FIRST"), .CLEAR(1)) u_rf (
        .clk(clk), .rst(rst), .wr_ce(wr_ce), .wr_we(wr_we), .wr_wmask(wr_wmask),
        .wr_addr(wr_addr), .wr_din(wr_din), .rd_ce(rd_ce), .rd_addr(rd_addr),
        .rd_dout(dr), .rd_valid(vr), .init_busy(br),
        .vss(1'b0), .vdd(1'b1), .vddio(1'b1), .ctrl(ctrl_z), .test(test_z));

    la_dpram_pipe #(.DW(DW), .AW(AW), .RDLAT(2), .COLLISION("WRITE_FIRST"), .CLEAR(1)) u2 (
        .clk(clk), .rst(rst), .wr_ce(wr_ce), .wr_we(wr_we), .wr_wmask(wr_wmask),
        .wr_addr(wr_addr), .wr_din(wr_din), .rd_ce(rd_ce), .rd_addr(rd_addr),
        .rd_dout(d2), .rd_valid(v2), .init_busy(b2),
        .vss(1'b0), .vdd(1'b1), .vddio(1'b1), .ctrl(ctrl_z), .test(test_z));

    la_dpram_pipe #(.DW(DW), .AW(AW), .DEPTH(12), .RDLAT(1), .COLLISION("WRITE_FIRST"), .CLEAR(1)) u12 (
        .clk(clk), .rst(rst), .wr_ce(wr_ce), .wr_we(wr_we), .wr_wmask(wr_wmask),
        .wr_addr(wr_addr), .wr_din(wr_din), .rd_ce(rd_ce), .rd_addr(rd_addr),
        .rd_dout(d12), .rd_valid(v12), .init_busy(b12),
        .vss(1'b0), .vdd(1'b1), .vddio(1'b1), .ctrl(ctrl_z), .test(test_z));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        wr_ce = 1'b1; wr_we = 1'b1; wr_addr = a; wr_din = d; wr_wmask = m;
        tick();
        wr_ce = 1'b0; wr_we = 1'b0;
    endtask

    task automatic test_reset();
        int done1;
        int done3;
        int done12;
        done1 = -1; done3 = -1; done12 = -1;
        rst = 1'b1;
        tick();
        checks++;
        if (b1 !== 1'b1 || v1 !== 1'b0 || d1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_state busy=%b valid=%b dout=%h, need 1 0 00", b1, v1, d1);
        end
        checks++;
        if (v3 !== 1'b0 || d3 !== 8'h00) begin
            errors++;
            $display("FAIL reset_pipe3 valid=%b dout=%h, need 0 00", v3, d3);
        end
        tick();
        rst = 1'b0;
        rd_ce = 1'b1; rd_addr = 4'd2;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done1 < 0 && b1 === 1'b0) done1 = k;
            if (done3 < 0 && b3 === 1'b0) done3 = k;
            if (done12 < 0 && b12 === 1'b0) done12 = k;
            if (k <= 16) begin
                checks++;
                if (v1 !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_read_ignored tick %0d valid=%b, need 0", k, v1);
                end
            end
        end
        rd_ce = 1'b0;
        checks++;
        if (done1 != 16 || done3 != 16) begin
            errors++;
            $display("FAIL clear_len16 cycles=%0d/%0d, need 16", done1, done3);
        end
        checks++;
        if (done12 != 12) begin
            errors++;
            $display("FAIL clear_len12 cycles=%0d, need 12", done12);
        end
        for (int i = 0; i < 16; i++) begin
            rd_ce = 1'b1; rd_addr = AW'(i);
            tick();
            checks++;
            if (v1 !== 1'b1 || d1 !== 8'h00) begin
                errors++;
                $display("FAIL clear_zero addr %0d valid=%b dout=%h, need 1 00", i, v1, d1);
            end
        end
        rd_ce = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_masked_write();
        wr(4'd3, 8'hFF, 8'hFF);
        wr(4'd3, 8'h00, 8'h0F);
        rd_ce = 1'b1; rd_addr = 4'd3;
        tick();
        rd_ce = 1'b0;
        checks++;
        if (v1 !== 1'b1 || d1 !== 8'hF0 || v3 !== 1'b0) begin
            errors++;
            $display("FAIL mask_lat1 valid=%b dout=%h v3=%b, need 1 f0 0", v1, d1, v3);
        end
        tick();
        checks++;
        if (v1 !== 1'b0 || d1 !== 8'hF0 || v3 !== 1'b0) begin
            errors++;
            $display("FAIL mask_hold valid=%b dout=%h v3=%b, need 0 f0 0", v1, d1, v3);
        end
        tick();
        checks++;
        if (v3 !== 1'b1 || d3 !== 8'hF0) begin
            errors++;
            $display("FAIL mask_lat3 valid=%b dout=%h, need 1 f0", v3, d3);
        end
        tick();
        checks++;
        if (v3 !== 1'b0 || d3 !== 8'hF0) begin
            errors++;
            $display("FAIL mask_lat3_hold valid=%b dout=%h, need 0 f0", v3, d3);
        end
    endtask

    task automatic test_collision();
        wr(4'd5, 8'h11, 8'hFF);
        wr_ce = 1'b1; wr_we = 1'b1; wr_addr = 4'd5; wr_din = 8'hAA; wr_wmask = 8'hFF;
        rd_ce = 1'b1; rd_addr = 4'd5;
        tick();
        wr_ce = 1'b0; wr_we = 1'b0;
        checks++;
        if (v1 !== 1'b1 || d1 !== 8'hAA || vr !== 1'b1 || dr !== 8'h11) begin
            errors++;
            $display("FAIL coll_full wf=%h rf=%h (v %b %b), need aa 11", d1, dr, v1, vr);
        end
        tick();
        checks++;
        if (d1 !== 8'hAA || dr !== 8'hAA) begin
            errors++;
            $display("FAIL coll_next wf=%h rf=%h, need aa aa", d1, dr);
        end
        wr_ce = 1'b1; wr_we = 1'b1; wr_addr = 4'd5; wr_din = 8'h0F; wr_wmask = 8'hF0;
        tick();
        wr_ce = 1'b0; wr_we = 1'b0;
        checks++;
        if (d1 !== 8'h0A || dr !== 8'hAA) begin
            errors++;
            $display("FAIL coll_masked wf=%h rf=%h, need 0a aa", d1, dr);
        end
        tick();
        rd_ce = 1'b0;
        checks++;
        if (d1 !== 8'h0A || dr !== 8'h0A) begin
            errors++;
            $display("FAIL coll_masked_next wf=%h rf=%h, need 0a 0a", d1, dr);
        end
        repeat (3) tick();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            wr(AW'(i), 8'h30 + DW'(i), 8'hFF);
        end
        for (int k = 0; k <= 9; k++) begin
            rd_ce = (k < 8);
            rd_addr = AW'(k);
            tick();
            checks++;
            if (k == 0 || k == 9) begin
                if (v2 !== 1'b0 || (k == 9 && d2 !== 8'h37)) begin
                    errors++;
                    $display("FAIL stream_idle tick %0d valid=%b dout=%h", k, v2, d2);
                end
            end else begin
                exp_d = 8'h30 + DW'(k - 1);
                if (v2 !== 1'b1 || d2 !== exp_d) begin
                    errors++;
                    $display("FAIL stream_data tick %0d valid=%b dout=%h, need 1 %h", k, v2, d2, exp_d);
                end
            end
        end
        rd_ce = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int done3;
        int bad_v;
        done3 = -1; bad_v = 0;
        rd_ce = 1'b1; rd_addr = 4'd3;
        tick();
        rd_addr = 4'd4;
        tick();
        rd_ce = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (v3 !== 1'b0 || d3 !== 8'h00 || b3 !== 1'b1) begin
            errors++;
            $display("FAIL rst_flush valid=%b dout=%h busy=%b, need 0 00 1", v3, d3, b3);
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (v3 !== 1'b0) bad_v++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 40 && done3 < 0; k++) begin
            tick();
            if (v3 !== 1'b0) bad_v++;
            if (b3 === 1'b0) done3 = k;
        end
        checks++;
        if (bad_v != 0) begin
            errors++;
            $display("FAIL rst_no_valid pulses=%0d, need 0", bad_v);
        end
        checks++;
        if (done3 != 16) begin
            errors++;
            $display("FAIL rst_reclear cycles=%0d, need 16", done3);
        end
        rd_ce = 1'b1; rd_addr = 4'd3;
        tick();
        checks++;
        if (v1 !== 1'b1 || d1 !== 8'h00) begin
            errors++;
            $display("FAIL reclear_addr3 valid=%b dout=%h, need 1 00", v1, d1);
        end
        rd_addr = 4'd7;
        tick();
        rd_ce = 1'b0;
        checks++;
        if (v1 !== 1'b1 || d1 !== 8'h00) begin
            errors++;
            $display("FAIL reclear_addr7 valid=%b dout=%h, need 1 00", v1, d1);
        end
        repeat (3) tick();
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] exp_d;
        wr(4'd11, 8'h77, 8'hFF);
        wr(4'd13, 8'h5A, 8'hFF);
        rd_ce = 1'b1; rd_addr = 4'd11;
        tick();
        checks++;
        if (v12 !== 1'b1 || d12 !== 8'h77) begin
            errors++;
            $display("FAIL oor_last valid=%b dout=%h, need 1 77", v12, d12);
        end
        rd_addr = 4'd13;
        tick();
        checks++;
        if (v12 !== 1'b1 || d12 !== 8'h00) begin
            errors++;
            $display("FAIL oor_read valid=%b dout=%h, need 1 00", v12, d12);
        end
        checks++;
        if (v1 !== 1'b1 || d1 !== 8'h5A) begin
            errors++;
            $display("FAIL full_depth_13 valid=%b dout=%h, need 1 5a", v1, d1);
        end
        for (int i = 0; i < 12; i++) begin
            rd_addr = AW'(i);
            tick();
            exp_d = (i == 11) ? 8'h77 : 8'h00;
            checks++;
            if (v12 !== 1'b1 || d12 !== exp_d) begin
                errors++;
                $display("FAIL oor_intact addr %0d valid=%b dout=%h, need 1 %h", i, v12, d12, exp_d);
            end
        end
        rd_ce = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        wr_ce = 1'b0; wr_we = 1'b0; wr_wmask = '0; wr_addr = '0; wr_din = '0;
        rd_ce = 1'b0; rd_addr = '0;
        test_reset();
        test_masked_write();
        test_collision();
        test_streaming();
        test_reset_mid();
        test_out_of_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/la_dpram_pipe.md
Name: la_dpram_pipe

Overview:
- Single-clock dual-port RAM: one write port and one read port, generalised from the basic 1W/1R lambda RAM.
- Adds configurable read latency with a valid strobe, a selectable same-address collision policy, and a hardware clear-on-reset sequencer.
- Used as the generic memory for FIFOs, register files and buffers.
- TYPE is passed through for hard-macro selection; the DEFAULT RTL model is specified here.

Parameters:
DW, 32, data width in bits
AW, 10, address width
DEPTH, 2**AW, number of implemented entries (1..2**AW)
RDLAT, 1, read latency in cycles (1..4)
COLLISION, "WRITE_FIRST", same-cycle same-address policy: "WRITE_FIRST" or "READ_FIRST"
CLEAR, 1, 1 = zero the whole array after reset; 0 = no clear
TYPE, "DEFAULT", hard-macro selector pass-through
CTRLW, 128, ASIC control interface width
TESTW, 128, ASIC test interface width

Ports:
clk  input  1  single clock for both ports
rst  input  1  synchronous active-high reset
wr_ce  input  1  write chip-enable
wr_we  input  1  write enable
wr_wmask  input  DW  per-bit write mask
wr_addr  input  AW  write address
wr_din  input  DW  write data
rd_ce  input  1  read request
rd_addr  input  AW  read address
rd_dout  output  DW  read data
rd_valid  output  1  rd_dout holds data for an accepted read (one-cycle pulse per read)
init_busy  output  1  clear sequence in progress; ports ignored
vss, vdd, vddio  input  1  power pass-through (unused in RTL)
ctrl  input  CTRLW  ASIC control pass-through (unused in RTL)
test  input  TESTW  ASIC test pass-through (unused in RTL)

Behaviour:
- Reset (rst=1 at edge):
  - rd_dout=0, rd_valid=0, all read-pipeline valid bits cleared.
  - FSM forced to CLEAR with clear address 0 when CLEAR=1, otherwise IDLE.
  - init_busy=1 while rst is high if CLEAR=1, otherwise 0.
  - Array contents are not reset by rst itself.
- FSM states: CLEAR, IDLE.
  - CLEAR: one entry written to 0 per cycle, addresses 0..DEPTH-1. Exits to IDLE on the edge that writes DEPTH-1, so init_busy is high for exactly DEPTH cycles after rst falls.
  - IDLE is terminal until the next rst.
  - rst during CLEAR restarts the sequence at address 0.
- While init_busy=1:
  - wr_ce and rd_ce are ignored, no write occurs and no read enters the pipeline.
  - rd_valid stays 0.
- Write (IDLE, wr_ce&wr_we at edge): bit i is updated from wr_din[i] only when wr_wmask[i]=1. When wr_addr>=DEPTH the write is dropped.
- Read (IDLE, rd_ce at edge T):
  - Fully pipelined; one read is accepted per cycle.
  - Data appears on rd_dout together with rd_valid=1 after edge T+RDLAT-1, i.e. sampled at edge T+RDLAT.
  - When rd_addr>=DEPTH the read returns 0 with rd_valid=1.
  - rd_dout holds its last value when no valid data is emerging; rd_valid=0 in those cycles.
- Collision (same edge, same address, write effective):
  - WRITE_FIRST: returned data = (wr_din & wr_wmask) | (old & ~wr_wmask).
  - READ_FIRST: returned data = old contents.
- Back-to-back: a write at edge T followed by a read of the same address at edge T+1 returns the new data in both modes.
- RDLAT>1: extra output register stages are added after the array read. Each stage carries data and valid, and all stages are cleared by rst.
- Read at edge T followed by rst at edge T+k with k<RDLAT: the read is discarded and rd_valid is never asserted for it.
- Widths: the read pipeline is DW data bits plus one valid bit per stage. The clear counter is AW+1 bits wide so that DEPTH=2**AW terminates correctly.

Test Plan:
- Clear: DW=8, AW=4, CLEAR=1; rst for 2 cycles, then release → init_busy high for exactly 16 cycles, then low; reading all 16 addresses returns 0x00.
- Masked write: write 0xFF to addr 3 with mask 0xFF, then write 0x00 with mask 0x0F → reading addr 3 returns 0xF0, with rd_valid exactly RDLAT cycles after rd_ce, for RDLAT=1 and RDLAT=3.
- Collision: addr 5 holds 0x11; same-cycle write 0xAA (mask 0xFF) plus read of addr 5 → WRITE_FIRST returns 0xAA; READ_FIRST returns 0x11; a read on the next cycle returns 0xAA in both modes.
- Streaming: RDLAT=2; reads of addr 0..7 on 8 consecutive cycles → rd_valid high for 8 consecutive cycles with data in order, then rd_valid low while rd_dout holds the addr 7 data.
- Reset mid-operation: assert rst with 2 reads in flight (RDLAT=3) and the clear sequence at address 6 → no rd_valid pulses; clear restarts at 0 and init_busy spans the full DEPTH cycles again.
- Out-of-range: DEPTH=12, AW=4; write 0x5A to addr 13, then read addr 13 → rd_dout=0 with rd_valid=1; addresses 0..11 are unchanged.
